// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam int unsigned DEFAULT_MEM_WORDS = 3000;

    // 65-bit FIFO entry: instruction, its byte address, out-of-range flag
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory, redirect and decode-side signals of the fetch unit.
interface instr_fetch_if;
    logic        mem_rd_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_pc;
    logic        out_fault;

    modport master (
        output mem_rd_en, mem_addr, out_valid, out_ir, out_pc, out_fault,
        input  mem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, out_valid, out_ir, out_pc, out_fault,
        output mem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Two-entry fetch buffer; one push and one pop per cycle, flush clears occupancy.
module fetch_fifo
    import instr_fetch_pkg::*;
(
    input  logic         clk_in,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         wr_en,
    input  fetch_entry_t wr_data,
    input  logic         rd_en,
    output fetch_entry_t rd_data,
    output logic [1:0]   count
);
    fetch_entry_t slots [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         rd_fire;

    assign rd_fire = rd_en && (count != 2'd0);
    assign rd_data = slots[rd_ptr];

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            slots[0] <= '0;
            slots[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                slots[wr_ptr] <= wr_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (rd_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr_en} - {1'b0, rd_fire};
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word reads from a synchronous RAM, buffers two
// results, handles redirects with an epoch bit and flags out-of-range PCs.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input logic           clk_in,
    input logic           reset_n,
    instr_fetch_if.master bus
);
    logic [31:0]  fpc;
    logic         epoch;
    logic         inflight;
    logic [31:0]  inflight_pc;
    logic         inflight_fault;
    logic         inflight_epoch;
    logic [1:0]   fifo_count;
    logic [1:0]   occupancy;
    logic         fpc_fault;
    logic         pop;
    logic         push;
    logic         issue;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    assign fpc_fault = ({2'b00, fpc[31:2]} >= MEM_WORDS);
    assign pop       = (fifo_count != 2'd0) && bus.out_ready;

    // A pop this cycle frees a slot, so it credits the issue decision;
    // without it a steady stream would stall every other cycle.
    assign occupancy = fifo_count + {1'b0, inflight} - {1'b0, pop};
    assign issue     = reset_n && !bus.redirect_valid && (occupancy < 2'd2);

    // Reads from before the latest redirect carry a stale epoch and are dropped.
    assign push = inflight && (inflight_epoch == epoch) && !bus.redirect_valid;

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = inflight_pc;
        wr_entry.fault = inflight_fault;
        wr_entry.ir    = inflight_fault ? NOP_INSTR : byte_swap(bus.mem_rdata);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            fpc            <= RESET_PC;
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_fault <= 1'b0;
            inflight_epoch <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= fpc;
                inflight_fault <= fpc_fault;
                inflight_epoch <= epoch;
                fpc            <= fpc + 32'd4;
            end
            if (bus.redirect_valid) begin
                fpc   <= bus.redirect_pc & ~32'h3;
                epoch <= ~epoch;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .flush   (bus.redirect_valid),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count)
    );

    assign bus.mem_rd_en = issue && !fpc_fault;
    assign bus.mem_addr  = fpc[13:2];
    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_ir    = head.ir;
    assign bus.out_pc    = head.pc;
    assign bus.out_fault = head.fault;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a synchronous big-endian RAM model.
module tb_instr_fetch;
    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    logic [31:0] ram [0:4095];

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (3000)
    ) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        // word i (i>=2) fetches as instruction 32'h0005_iiB3
        ram[0] = 32'h3700_0000;
        ram[1] = 32'h1300_0000;
        for (int i = 2; i < 4096; i++) ram[i] = {8'hB3, 8'(i), 8'h05, 8'h00};
        bus.mem_rdata      = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;

        // reset state
        step(); step();
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_rd_en", bus.mem_rd_en, 1'b0);
        chk("rst_ir", bus.out_ir, 32'h0);
        chk("rst_pc", bus.out_pc, 32'h0);
        chk("rst_fault", bus.out_fault, 1'b0);

        // basic fetch, then redirect to 0x40 while pc=8 is in flight
        reset_n = 1'b1; bus.out_ready = 1'b1; #1;
        chk("s1_c0_rd_en", bus.mem_rd_en, 1'b1);
        chk("s1_c0_addr", bus.mem_addr, 12'h000);
        chk("s1_c0_valid", bus.out_valid, 1'b0);
        step();
        chk("s1_c1_valid", bus.out_valid, 1'b0);
        chk("s1_c1_addr", bus.mem_addr, 12'h001);
        step();
        chk("s1_c2_valid", bus.out_valid, 1'b1);
        chk("s1_c2_ir", bus.out_ir, 32'h0000_0037);
        chk("s1_c2_pc", bus.out_pc, 32'h0);
        chk("s1_c2_fault", bus.out_fault, 1'b0);
        step();
        chk("s1_c3_ir", bus.out_ir, 32'h0000_0013);
        chk("s1_c3_pc", bus.out_pc, 32'h4);
        bus.out_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; #1;
        chk("s1_redir_rd_en", bus.mem_rd_en, 1'b0);
        step();
        bus.redirect_valid = 1'b0; #1;
        chk("s1_r1_valid", bus.out_valid, 1'b0);
        chk("s1_r1_rd_en", bus.mem_rd_en, 1'b1);
        chk("s1_r1_addr", bus.mem_addr, 12'h010);
        step();
        chk("s1_r2_valid", bus.out_valid, 1'b0);
        step();
        chk("s1_r3_valid", bus.out_valid, 1'b1);
        chk("s1_r3_pc", bus.out_pc, 32'h40);
        chk("s1_r3_ir", bus.out_ir, 32'h0005_10B3);
        step();
        chk("s1_r4_pc", bus.out_pc, 32'h40);

        // backpressure: two entries buffered, no reads, stable head
        reset_n = 1'b0; bus.out_ready = 1'b0;
        step();
        reset_n = 1'b1; #1;
        chk("s2_c0_rd_en", bus.mem_rd_en, 1'b1);
        step();
        chk("s2_c1_valid", bus.out_valid, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("s2_hold_valid", bus.out_valid, 1'b1);
            chk("s2_hold_pc", bus.out_pc, 32'h0);
            chk("s2_hold_ir", bus.out_ir, 32'h0000_0037);
            chk("s2_hold_rd_en", bus.mem_rd_en, 1'b0);
            step();
        end
        bus.out_ready = 1'b1; #1;
        chk("s2_c7_pc", bus.out_pc, 32'h0);
        chk("s2_c7_rd_en", bus.mem_rd_en, 1'b1);
        chk("s2_c7_addr", bus.mem_addr, 12'h002);
        step();
        chk("s2_c8_valid", bus.out_valid, 1'b1);
        chk("s2_c8_pc", bus.out_pc, 32'h4);
        step();
        chk("s2_c9_valid", bus.out_valid, 1'b1);
        chk("s2_c9_pc", bus.out_pc, 32'h8);
        chk("s2_c9_ir", bus.out_ir, 32'h0005_02B3);

        // handshake at pc=4 together with redirect to 0x100
        reset_n = 1'b0; bus.out_ready = 1'b1;
        step();
        reset_n = 1'b1;
        step(); step();
        chk("s3_c2_pc", bus.out_pc, 32'h0);
        step();
        chk("s3_c3_pc", bus.out_pc, 32'h4);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; #1;
        chk("s3_redir_rd_en", bus.mem_rd_en, 1'b0);
        step();
        bus.redirect_valid = 1'b0; #1;
        chk("s3_r1_valid", bus.out_valid, 1'b0);
        step();
        chk("s3_r2_valid", bus.out_valid, 1'b0);
        step();
        chk("s3_r3_valid", bus.out_valid, 1'b1);
        chk("s3_r3_pc", bus.out_pc, 32'h100);
        chk("s3_r3_ir", bus.out_ir, 32'h0005_40B3);
        step();
        chk("s3_r4_pc", bus.out_pc, 32'h104);
        chk("s3_r4_ir", bus.out_ir, 32'h0005_41B3);

        // redirect to word 3000: out-of-range fetch
        bus.out_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h2EE0;
        step();
        bus.redirect_valid = 1'b0; #1;
        chk("s4_r1_rd_en", bus.mem_rd_en, 1'b0);
        chk("s4_r1_addr", bus.mem_addr, 12'hBB8);
        chk("s4_r1_valid", bus.out_valid, 1'b0);
        step();
        chk("s4_r2_valid", bus.out_valid, 1'b0);
        chk("s4_r2_rd_en", bus.mem_rd_en, 1'b0);
        step();
        chk("s4_r3_valid", bus.out_valid, 1'b1);
        chk("s4_r3_pc", bus.out_pc, 32'h2EE0);
        chk("s4_r3_fault", bus.out_fault, 1'b1);
        chk("s4_r3_ir", bus.out_ir, 32'h0000_0013);
        step();
        chk("s4_r4_pc", bus.out_pc, 32'h2EE0);

        // reset with the FIFO full
        reset_n = 1'b0; #1;
        chk("s5_rst_valid", bus.out_valid, 1'b0);
        chk("s5_rst_rd_en", bus.mem_rd_en, 1'b0);
        chk("s5_rst_pc", bus.out_pc, 32'h0);
        chk("s5_rst_ir", bus.out_ir, 32'h0);
        chk("s5_rst_fault", bus.out_fault, 1'b0);
        step();
        reset_n = 1'b1; bus.out_ready = 1'b1; #1;
        chk("s5_c0_addr", bus.mem_addr, 12'h000);
        step(); step();
        chk("s5_c2_valid", bus.out_valid, 1'b1);
        chk("s5_c2_pc", bus.out_pc, 32'h0);
        chk("s5_c2_ir", bus.out_ir, 32'h0000_0037);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
